// File: rtl/contador_de_programa.sv
// Program counter with fetch/wait/halt sequencing and a saturating retired-instruction counter.
// Decodes only the opcode and target fields of the fetched word.
module contador_de_programa #(
    parameter logic [31:0] ENDERECO_INICIAL = 32'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        desvio,
    input  logic [31:0] registrador,
    input  logic        entrada_valida,
    input  logic        congela,
    output logic [31:0] endereco,
    output logic [31:0] retorno,
    output logic        esperando,
    output logic        parado,
    output logic [15:0] contador_instrucoes
);

    localparam logic [1:0] StInicio = 2'd0;
    localparam logic [1:0] StBusca  = 2'd1;
    localparam logic [1:0] StEspera = 2'd2;
    localparam logic [1:0] StParado = 2'd3;

    localparam logic [4:0] OpDesvio    = 5'd12;
    localparam logic [4:0] OpSalto     = 5'd16;
    localparam logic [4:0] OpParada    = 5'd18;
    localparam logic [4:0] OpEntrada   = 5'd19;
    localparam logic [4:0] OpSaltoReg  = 5'd27;

    logic [1:0]  estado_q, estado_d;
    logic [31:0] endereco_q, endereco_d;
    logic [15:0] contador_q, contador_d;
    logic [4:0]  opcode;
    logic [31:0] proximo;
    logic        retira;

    assign opcode  = instrucao[31:27];
    assign proximo = endereco_q + 32'd1;

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        retira     = 1'b0;
        if (!congela) begin
            unique case (estado_q)
                StInicio: estado_d = StBusca;
                StBusca: begin
                    retira = 1'b1;
                    case (opcode)
                        OpSalto:    endereco_d = {5'b0, instrucao[26:0]};
                        OpDesvio:   endereco_d = desvio ? {15'b0, instrucao[16:0]} : proximo;
                        OpSaltoReg: endereco_d = registrador;
                        OpParada:   estado_d   = StParado;
                        OpEntrada: begin
                            // Missing input parks the instruction; it retires on leaving ESPERA.
                            if (entrada_valida) begin
                                endereco_d = proximo;
                            end else begin
                                estado_d = StEspera;
                                retira   = 1'b0;
                            end
                        end
                        default:    endereco_d = proximo;
                    endcase
                end
                StEspera: begin
                    if (entrada_valida) begin
                        endereco_d = proximo;
                        estado_d   = StBusca;
                        retira     = 1'b1;
                    end
                end
                StParado: estado_d = StParado;
                default:  estado_d = StInicio;
            endcase
        end
    end

    always_comb begin
        contador_d = contador_q;
        if (retira && (contador_q != 16'hFFFF)) begin
            contador_d = contador_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= StInicio;
            endereco_q <= ENDERECO_INICIAL;
            contador_q <= 16'd0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            contador_q <= contador_d;
        end
    end

    assign endereco            = endereco_q;
    assign retorno             = proximo;
    assign esperando           = (estado_q == StEspera);
    assign parado              = (estado_q == StParado);
    assign contador_instrucoes = contador_q;

endmodule
